// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: transmit FSM encoding, 8N1 frame constants and the
// bit period that the 64-bit receiver and transmitter both use.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    localparam int   DATA_BITS        = 8;
    localparam int   BYTES_PER_BLOCK  = 8;
    localparam logic IDLE_LEVEL       = 1'b1;
    localparam int   BAUD_DIV_DEFAULT = 44;

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-period down-counter: one-cycle tick every BAUD_DIV cycles, held off by clear.
// The first tick after clear drops comes BAUD_DIV cycles later; no backpressure.
module rs232_baud_tick
    import rs232_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0) && !clear;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear || tick) begin
            cnt_d = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rs232_tx64.sv
// Serialises one 64-bit block as eight 8N1 frames, MSB byte and MSB bit first.
// Start bit on the cycle after acceptance; start is ignored while busy (no queueing).
module rs232_tx64
    import rs232_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int GAP_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [2:0]  byte_idx
);

    localparam int            W         = DATA_BITS * BYTES_PER_BLOCK;
    localparam int            GW        = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(BYTES_PER_BLOCK - 1);

    tx_state_e     state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          tick;
    logic          byte_end;

    rs232_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        byte_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = data_in;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // The whole block shifts, so the next byte's MSB is already on top.
                if (tick) begin
                    shift_d = {shift_q[W-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (GAP_BITS > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        byte_end = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        byte_end = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (byte_end) begin
            if (byte_q == LAST_BYTE) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                byte_d  = byte_q + 1'b1;
                state_d = ST_START;
            end
        end

        // Line level follows the next state so tx changes on the same edge as the FSM.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[W-1];
            default:  tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign byte_idx = byte_q;

endmodule

// File: tb/tb_rs232_tx64.sv
// Bench for rs232_tx64: a no-gap and a two-bit-gap instance checked every cycle
// against a waveform model computed from frame arithmetic, plus directed sequences.
module tb_rs232_tx64;

    localparam int B   = 44;
    localparam int G1  = 2;
    localparam int FL0 = 10 * B;
    localparam int L0  = 8 * FL0;
    localparam int FL1 = (10 + G1) * B;
    localparam int L1  = 8 * FL1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic [63:0] din_s   [2];
    logic        tx_s    [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [2:0]  idx_s   [2];

    always #10 clk = ~clk;

    rs232_tx64 #(.BAUD_DIV(B), .GAP_BITS(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .data_in(din_s[0]),
        .tx(tx_s[0]), .busy(busy_s[0]), .done(done_s[0]), .byte_idx(idx_s[0])
    );

    rs232_tx64 #(.BAUD_DIV(B), .GAP_BITS(G1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .data_in(din_s[1]),
        .tx(tx_s[1]), .busy(busy_s[1]), .done(done_s[1]), .byte_idx(idx_s[1])
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          have  [2];
    int          t0    [2];
    logic [63:0] mword [2];

    typedef struct {
        logic [63:0] data;
        logic [63:0] exp_bytes;
        int          exp_done;
    } vec_t;

    function automatic int frame_len(input int i);
        return (i == 1) ? FL1 : FL0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {tx, busy, done, byte_idx}, k0 = cycles since the accepting edge.
    function automatic logic [5:0] model(input int i, input int k0);
        int         fl;
        int         f;
        int         p;
        logic [7:0] by;
        logic       t;
        fl = frame_len(i);
        if (!have[i] || k0 > 8 * fl) return 6'b100_000;
        if (k0 == 8 * fl) return 6'b101_000;
        f  = k0 / fl;
        p  = (k0 % fl) / B;
        by = mword[i][63 - 8 * f -: 8];
        if (p == 0)      t = 1'b0;
        else if (p <= 8) t = by[8 - p];
        else             t = 1'b1;
        return {t, 1'b1, 1'b0, 3'(f)};
    endfunction

    task automatic step();
        logic [5:0] e;
        logic [5:0] a;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                have[i] = 1'b0;
            end else if ((!have[i] || (cyc - 1 - t0[i]) >= 8 * frame_len(i)) && start_s[i]) begin
                have[i]  = 1'b1;
                t0[i]    = cyc;
                mword[i] = din_s[i];
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = model(i, cyc - t0[i]);
            a = {tx_s[i], busy_s[i], done_s[i], idx_s[i]};
            if (!e[4]) a[2:0] = 3'd0;
            check($sformatf("dut%0d_cyc%0d", i, cyc), 64'(a), 64'(e));
        end
    endtask

    task automatic send_block(input int i, input logic [63:0] w, input int inject_k, input int run_len,
                              output logic [63:0] bytes, output int first_done, output int ndone,
                              output bit framing_ok);
        logic cap [$];
        int   fl;
        int   base;
        start_s[i] = 1'b1;
        din_s[i]   = w;
        step();
        start_s[i] = 1'b0;
        din_s[i]   = ~w;
        first_done = -1;
        ndone      = 0;
        for (int k = 0; k < run_len; k++) begin
            cap.push_back(tx_s[i]);
            if (done_s[i]) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            start_s[i] = (k == inject_k);
            if (k == inject_k) din_s[i] = '1;
            step();
        end
        start_s[i] = 1'b0;
        fl         = frame_len(i);
        bytes      = '0;
        framing_ok = 1'b1;
        for (int f = 0; f < 8; f++) begin
            base = f * fl + B / 2;
            if (cap[base] !== 1'b0) framing_ok = 1'b0;
            for (int j = 0; j < 8; j++) bytes = {bytes[62:0], cap[base + (1 + j) * B]};
            for (int s = 9; s < fl / B; s++) if (cap[base + s * B] !== 1'b1) framing_ok = 1'b0;
        end
    endtask

    initial begin
        vec_t        vecs [3];
        logic [63:0] bytes;
        int          fd;
        int          nd;
        bit          ok;
        int          d1;
        int          d2;

        vecs[0] = '{64'h02010FAA553CC303, {8'h02, 8'h01, 8'h0F, 8'hAA, 8'h55, 8'h3C, 8'hC3, 8'h03}, 3520};
        vecs[1] = '{64'h8000000000000001, {8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 3520};
        vecs[2] = '{64'h0123456789ABCDEF, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}, 3520};

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            din_s[i]   = '0;
        end
        for (int c = 0; c < 3; c++) step();
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_state%0d", i), 64'({tx_s[i], busy_s[i], done_s[i], idx_s[i]}), 64'(6'b100_000));

        rst = 1'b1;
        nd  = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            if (done_s[0] || done_s[1]) nd++;
        end
        check("idle_no_done", 64'(nd), 64'd0);

        for (int v = 0; v < 3; v++) begin
            send_block(0, vecs[v].data, -1, L0 + 20, bytes, fd, nd, ok);
            check($sformatf("vec%0d_bytes", v), bytes, vecs[v].exp_bytes);
            check($sformatf("vec%0d_done_lat", v), 64'(fd), 64'(vecs[v].exp_done));
            check($sformatf("vec%0d_ndone", v), 64'(nd), 64'd1);
            check($sformatf("vec%0d_framing", v), 64'(ok), 64'd1);
        end

        send_block(0, vecs[0].data, 3 * FL0 + 5 * B, L0 + 20, bytes, fd, nd, ok);
        check("busy_start_bytes", bytes, vecs[0].exp_bytes);
        check("busy_start_ndone", 64'(nd), 64'd1);
        check("busy_start_done_lat", 64'(fd), 64'(L0));

        start_s[1] = 1'b1;
        din_s[1]   = 64'h0;
        step();
        din_s[1] = '1;
        nd = 0;
        d1 = -1;
        d2 = -1;
        for (int k = 0; k < 2 * L1 + 100; k++) begin
            if (done_s[1]) begin
                nd++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (d1 >= 0 && k == d1 + 1) begin
                check("b2b_restart", 64'({tx_s[1], busy_s[1]}), 64'(2'b01));
                start_s[1] = 1'b0;
            end
            step();
        end
        start_s[1] = 1'b0;
        check("b2b_ndone", 64'(nd), 64'd2);
        check("b2b_first_done", 64'(d1), 64'(L1));
        check("b2b_spacing", 64'(d2 - d1), 64'(L1 + 1));

        start_s[0] = 1'b1;
        din_s[0]   = 64'h0;
        step();
        start_s[0] = 1'b0;
        for (int k = 0; k < 5 * FL0 + 5 * B + 10; k++) step();
        check("midframe_pre_tx", 64'(tx_s[0]), 64'd0);
        rst = 1'b0;
        #1;
        check("midframe_async", 64'({tx_s[0], busy_s[0], done_s[0], idx_s[0]}), 64'(6'b100_000));
        step();
        step();
        rst = 1'b1;
        step();
        send_block(0, 64'hC3A55A3C0FF01234, -1, L0 + 20, bytes, fd, nd, ok);
        check("after_reset_bytes", bytes, 64'hC3A55A3C0FF01234);
        check("after_reset_done_lat", 64'(fd), 64'(L0));

        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < 2; i++) begin
                start_s[i] = ($urandom_range(0, 99) < 3);
                din_s[i]   = {$urandom, $urandom};
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
